pll_pocket_rst: RTL and testbench
=================================

Name: pll_pocket_rst

Overview:
Lock-qualified reset sequencer and clock-enable generator for the Pocket 27 MHz core clock domain. It sits directly downstream of the Pocket PLL, runs on the PLL's 27 MHz output, and watches the PLL `locked` flag. It releases the core reset only after lock has been continuously stable, then generates a divided clock enable.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for `locked`. Must be ≥2.
- LOCK_CYCLES, 1024: consecutive synchronized-lock cycles required before the reset hold starts. Must be ≥1.
- HOLD_CYCLES, 16: cycles the core reset stays asserted after lock qualifies. Must be ≥1.
- CEN_DIV, 4: clock-enable division ratio (27 MHz/4 = 6.75 MHz). Must be ≥1.

Ports:
- clk  in  1  27 MHz PLL output clock (outclk_0).
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock flag, asynchronous to clk.
- soft_rst  in  1  synchronous request to re-run the hold phase.
- rst_out  out  1  core reset, active-high. Asserts asynchronously, deasserts synchronously.
- ready  out  1  high while in RUN.
- cen  out  1  single-cycle clock-enable pulse every CEN_DIV cycles in RUN.

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- While `rst` is high, all registers are cleared:
  - state = WAIT_LOCK
  - rst_out = 1, ready = 0, cen = 0
  - lock counter, hold counter and div counter = 0
  - all synchronizer flops = 0
- `locked` passes through a SYNC_STAGES-flop chain; the last flop is `lock_s`. Only `lock_s` is used internally.
- States and transitions (all registered; lock_s = 0 takes priority in every state):
  - WAIT_LOCK: lock_s = 1 → SETTLE, cnt = 0.
  - SETTLE: lock_s = 0 → WAIT_LOCK. cnt == LOCK_CYCLES-1 → HOLD, cnt = 0. Otherwise cnt++. soft_rst is ignored.
  - HOLD: lock_s = 0 → WAIT_LOCK. soft_rst → cnt = 0, stay in HOLD. cnt == HOLD_CYCLES-1 → RUN. Otherwise cnt++.
  - RUN: lock_s = 0 → WAIT_LOCK. soft_rst → HOLD, cnt = 0.
- Outputs:
  - rst_out is registered as rst_out <= (next_state != RUN).
  - ready <= (next_state == RUN).
  - Both therefore change on the same edge the state enters or leaves RUN.
- Timing:
  - Lock-to-release latency: rst_out falls on edge SYNC_STAGES+1+LOCK_CYCLES+HOLD_CYCLES, counting the first edge after `locked` rises as edge 1.
  - Lock-loss latency: rst_out rises SYNC_STAGES+1 edges after `locked` falls.
  - A `locked` glitch shorter than one clock may be missed; this is acceptable.
- Clock enable:
  - div_cnt is held at 0 whenever next_state != RUN.
  - In RUN, div_cnt counts 0..CEN_DIV-1 and wraps.
  - cen is registered, high when div_cnt == CEN_DIV-1; the first cen falls in RUN cycle index CEN_DIV-1 (first RUN cycle = 0).
  - cen = 0 outside RUN, including the cycle of the transition out of RUN.
  - CEN_DIV = 1 → cen is constantly high in RUN.
- Counter width is $clog2 of the largest of LOCK_CYCLES/HOLD_CYCLES, minimum 1 bit. Counters never overflow: they stop at the terminal compare.
- `rst` asserted mid-operation forces every output to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Shared package: state enum (WAIT_LOCK = 0, SETTLE = 1, HOLD = 2, RUN = 3) and default parameter constants.
- One natural sub-module, pll_pocket_sync: a SYNC_STAGES-deep single-bit synchronizer with async reset to 0. Reused for `locked`.
- The state machine and cen divider stay in the top module.

Test Plan (LOCK_CYCLES=8, HOLD_CYCLES=4, CEN_DIV=4, SYNC_STAGES=2):
1. Release rst with locked = 1 from the start → rst_out = 1, ready = 0 until edge 15 after rst deassert; then rst_out = 0, ready = 1. First cen pulse on edge 18, then on edges 22, 26, …
2. locked toggles high 5 cycles, then low, then high again → state returns to WAIT_LOCK, rst_out stays 1. Release occurs 15 edges after the final locked rise.
3. In RUN, drop locked → rst_out = 1, ready = 0, cen = 0 on edge 3 after the fall. Re-raising locked repeats the full 15-edge sequence.
4. In RUN, pulse soft_rst for 1 cycle → next edge rst_out = 1. Release occurs 4 edges later. The cen phase restarts, with the first pulse 3 edges after release.
5. Assert soft_rst during HOLD at cnt = 2 → hold count restarts; release occurs 4 edges after soft_rst drops.
6. Assert rst asynchronously mid-RUN, between edges → rst_out = 1, ready = 0, cen = 0 immediately. The sequence restarts from WAIT_LOCK after rst is released.

Source files
------------

// File: rtl/pll_pocket_rst_pkg.sv
// rtl/pll_pocket_rst_pkg.sv - shared state encoding, default parameters and sizing helper for pll_pocket_rst
package pll_pocket_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_CEN_DIV     = 4;

    // Width of the shared settle/hold counter: wide enough for the larger
    // terminal count, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_pocket_rst_sync.sv
// rtl/pll_pocket_rst_sync.sv - single-bit multi-flop synchronizer with asynchronous clear
//
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high clear of every stage
//   d    in   asynchronous input bit
//   q    out  synchronized bit (last stage)
module pll_pocket_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_pocket_rst.sv
// rtl/pll_pocket_rst.sv - lock-qualified core reset sequencer and divided clock-enable generator
//
// Ports:
//   clk       in   PLL output clock
//   rst       in   asynchronous active-high reset
//   locked    in   PLL lock flag, asynchronous to clk
//   soft_rst  in   synchronous request to re-run the hold phase
//   rst_out   out  core reset, active-high; asserts asynchronously, releases on clk
//   ready     out  high while the sequencer is in RUN
//   cen       out  one-cycle enable pulse every CEN_DIV cycles while in RUN
module pll_pocket_rst
    import pll_pocket_rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CEN_DIV     = DEF_CEN_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic soft_rst,
    output logic rst_out,
    output logic ready,
    output logic cen
);

    localparam int CW = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
    localparam int DW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CEN_DIV - 1);

    logic lock_s;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [DW-1:0] div_cnt, div_next;
    logic          cen_next;

    pll_pocket_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            div_cnt <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
            cen     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            div_cnt <= div_next;
            rst_out <= (state_next != RUN);
            ready   <= (state_next == RUN);
            cen     <= cen_next;
        end
    end

    // Loss of lock wins over everything else in every state. The counter
    // stops at its terminal compare, so it can never wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (soft_rst) begin
                    cnt_next = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (soft_rst) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // div_cnt equals the RUN cycle index modulo CEN_DIV: it is forced to 0
    // on the entry edge and whenever RUN is being left. cen looks at the
    // value being loaded so the pulse lands in the cycle where div_cnt is
    // at its last count (every RUN cycle when CEN_DIV is 1).
    always_comb begin
        div_next = '0;
        if ((state_next == RUN) && (state == RUN)) begin
            div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
        cen_next = (state_next == RUN) && (div_next == DIV_LAST);
    end

endmodule

// File: tb/tb_pll_pocket_rst.sv
// tb/tb_pll_pocket_rst.sv - scoreboard bench for pll_pocket_rst with LOCK=8, HOLD=4, CEN_DIV=4, SYNC=2
module tb_pll_pocket_rst;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b0;
    logic soft_rst = 1'b0;
    logic rst_out;
    logic ready;
    logic cen;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [2:0] prev = 3'b100;

    typedef struct {
        int         c;
        logic [2:0] v;
    } ev_t;
    ev_t exp_q[$];

    pll_pocket_rst #(
        .SYNC_STAGES (2),
        .LOCK_CYCLES (8),
        .HOLD_CYCLES (4),
        .CEN_DIV     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .soft_rst (soft_rst),
        .rst_out  (rst_out),
        .ready    (ready),
        .cen      (cen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector {rst_out, ready, cen} after a change, tagged with
    // the number of the clock edge on (or after) which it must appear.
    task automatic push(input int c, input logic [2:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: every change of the output vector is matched against the
    // head of the expectation queue, both in value and in edge number.
    always @(negedge clk) begin
        logic [2:0] cur;
        ev_t e;
        cur = {rst_out, ready, cen};
        if (mon_en && (cur !== prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d actual=%b required=none", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if ((e.c != cyc) || (e.v !== cur)) begin
                    errors++;
                    $display("FAIL out_event actual cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, cur, e.c, e.v);
                end
            end
        end
        prev = cur;
    end

    initial begin
        // Reset state, locked already high.
        locked = 1'b1;
        goto(3);
        check("reset_outputs", {rst_out, ready, cen}, 3'b100);
        prev   = 3'b100;
        mon_en = 1'b1;

        // 1: release rst with lock present; release on edge 15 after, cen 3 later.
        goto(5);
        rst = 1'b0;
        push(20, 3'b010);
        push(23, 3'b011);
        push(24, 3'b010);
        push(27, 3'b011);
        push(28, 3'b010);

        // 3: lock loss in RUN; last cen still lands, reset 3 edges after the fall.
        goto(29);
        locked = 1'b0;
        push(31, 3'b011);
        push(32, 3'b100);
        goto(35);
        locked = 1'b1;
        push(50, 3'b010);
        push(53, 3'b011);
        push(54, 3'b010);
        goto(55);
        locked = 1'b0;
        push(57, 3'b011);
        push(58, 3'b100);

        // 2: lock glitch during SETTLE; release timed from the final rise.
        goto(61);
        locked = 1'b1;
        goto(66);
        check("glitch_still_reset", {rst_out, ready, cen}, 3'b100);
        locked = 1'b0;
        goto(69);
        locked = 1'b1;
        push(84, 3'b010);
        push(87, 3'b011);
        push(88, 3'b010);

        // 4: one-cycle soft_rst in RUN re-runs the hold phase.
        goto(89);
        soft_rst = 1'b1;
        goto(90);
        soft_rst = 1'b0;
        push(90, 3'b100);
        push(94, 3'b010);
        push(97, 3'b011);
        push(98, 3'b010);

        // 5: soft_rst in HOLD at cnt=2 restarts the hold count.
        goto(98);
        soft_rst = 1'b1;
        goto(99);
        soft_rst = 1'b0;
        push(99, 3'b100);
        goto(101);
        soft_rst = 1'b1;
        goto(102);
        soft_rst = 1'b0;
        goto(105);
        check("hold_restart_still_reset", {rst_out, ready, cen}, 3'b100);
        push(106, 3'b010);
        push(109, 3'b011);
        push(110, 3'b010);

        // 6: asynchronous rst mid-RUN while cen is high.
        goto(113);
        check("cen_before_async_rst", {rst_out, ready, cen}, 3'b011);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_immediate", {rst_out, ready, cen}, 3'b100);
        push(113, 3'b100);
        goto(116);
        rst = 1'b0;
        push(131, 3'b010);
        push(134, 3'b011);
        push(135, 3'b010);

        goto(138);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event actual=none required cyc=%0d val=%b", e.c, e.v);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
